// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key expansion: captures a cipher key on start, derives round keys
// 1..10 one per clock, and serves all 11 round keys through a combinational read port.
`timescale 1ns/1ps

module aes_key_expand_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [0:127] rd_key
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Forward S-box, entry 0 at the left; byte b lives at bits [8*b +: 8].
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TABLE[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [0:31] sub_word(input logic [0:31] w);
    return {sub_byte(w[0:7]), sub_byte(w[8:15]), sub_byte(w[16:23]), sub_byte(w[24:31])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_r;
  logic [3:0]   cnt_r;
  logic [0:127] rk_r [0:10];

  logic [0:127] prev_key_s;
  logic [0:31]  rot_s;
  logic [0:31]  temp_s;
  logic [0:31]  n0_s, n1_s, n2_s, n3_s;
  logic [0:127] next_key_s;

  // Round function applied to the previously stored key rk[cnt-1].
  always_comb begin
    prev_key_s = 128'h0;
    if ((cnt_r >= 4'd1) && (cnt_r <= 4'd10)) begin
      prev_key_s = rk_r[cnt_r - 4'd1];
    end else begin
      prev_key_s = 128'h0;
    end
    rot_s      = {prev_key_s[104:127], prev_key_s[96:103]};
    temp_s     = sub_word(rot_s) ^ {rcon(cnt_r), 24'h000000};
    n0_s       = prev_key_s[0:31]   ^ temp_s;
    n1_s       = prev_key_s[32:63]  ^ n0_s;
    n2_s       = prev_key_s[64:95]  ^ n1_s;
    n3_s       = prev_key_s[96:127] ^ n2_s;
    next_key_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // Control FSM, round counter, registered status flags and round-key storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        rk_r[i] <= 128'h0;
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            rk_r[0]    <= key;
            cnt_r      <= 4'd1;
            state_r    <= S_EXPAND;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
        S_EXPAND: begin
          // start is deliberately ignored here: no recapture, counter untouched.
          rk_r[cnt_r] <= next_key_s;
          if (cnt_r == 4'd10) begin
            cnt_r      <= 4'd0;
            state_r    <= S_DONE;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            done       <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          cnt_r      <= 4'd0;
          busy       <= 1'b0;
          keys_valid <= 1'b0;
        end
      endcase
    end
  end

  // Indexed read of stored round keys; out-of-range indices read as zero.
  always_comb begin
    rd_key = 128'h0;
    if (rd_idx <= 4'd10) begin
      rd_key = rk_r[rd_idx];
    end else begin
      rd_key = 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed self-checking bench for aes_key_expand_seq using FIPS-197 A.1 and all-zero key vectors.
`timescale 1ns/1ps

module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int vectors;
  int miscompares;

  logic [127:0] a1_keys [0:10];
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key with start for exactly one edge; returns just after that edge (E).
  task automatic pulse_start(input logic [127:0] k);
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
    key   = 128'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, keys_valid, done} !== 3'b000) begin
      $display("FAIL reset_flags: got busy/valid/done=%b, want 000", {busy, keys_valid, done});
      miscompares++;
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      vectors++;
      if (rd_key !== 128'h0) begin
        $display("FAIL reset_rd_key[%0d]: got %h, want 0", i, rd_key);
        miscompares++;
      end
    end
  endtask

  task automatic test_fips_a1();
    pulse_start(a1_keys[0]);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({busy, keys_valid, done} !== 3'b100) begin
        $display("FAIL a1_busy_E+%0d: got busy/valid/done=%b, want 100", k, {busy, keys_valid, done});
        miscompares++;
      end
      tick();
    end
    vectors++;
    if ({busy, keys_valid, done} !== 3'b011) begin
      $display("FAIL a1_done_E+10: got busy/valid/done=%b, want 011", {busy, keys_valid, done});
      miscompares++;
    end
    tick();
    vectors++;
    if ({busy, keys_valid, done} !== 3'b010) begin
      $display("FAIL a1_after_done: got busy/valid/done=%b, want 010", {busy, keys_valid, done});
      miscompares++;
    end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      #1;
      vectors++;
      if (rd_key !== a1_keys[i]) begin
        $display("FAIL a1_rk[%0d]: got %h, want %h", i, rd_key, a1_keys[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_restart_from_done();
    pulse_start(128'h0);
    vectors++;
    if ({busy, keys_valid, done} !== 3'b100) begin
      $display("FAIL restart_valid_drop: got busy/valid/done=%b, want 100", {busy, keys_valid, done});
      miscompares++;
    end
    repeat (10) tick();
    vectors++;
    if ({busy, keys_valid, done} !== 3'b011) begin
      $display("FAIL restart_done: got busy/valid/done=%b, want 011", {busy, keys_valid, done});
      miscompares++;
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (rd_key !== ZERO_RK10) begin
      $display("FAIL restart_rk10: got %h, want %h", rd_key, ZERO_RK10);
      miscompares++;
    end
  endtask

  task automatic test_zero_key();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start(128'h0);
    repeat (10) tick();
    vectors++;
    if (done !== 1'b1) begin
      $display("FAIL zero_done: got %b, want 1", done);
      miscompares++;
    end
    rd_idx = 4'd1;
    #1;
    vectors++;
    if (rd_key !== ZERO_RK1) begin
      $display("FAIL zero_rk1: got %h, want %h", rd_key, ZERO_RK1);
      miscompares++;
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (rd_key !== ZERO_RK10) begin
      $display("FAIL zero_rk10: got %h, want %h", rd_key, ZERO_RK10);
      miscompares++;
    end
    rd_idx = 4'd12;
    #1;
    vectors++;
    if (rd_key !== 128'h0) begin
      $display("FAIL zero_rk12: got %h, want 0", rd_key);
      miscompares++;
    end
  endtask

  task automatic test_start_ignored();
    int done_count;
    int done_at;
    done_count = 0;
    done_at    = -1;
    pulse_start(a1_keys[0]);
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin
        start = 1'b1;
        key   = 128'hffeeddccbbaa99887766554433221100;
      end else begin
        start = 1'b0;
        key   = 128'h0;
      end
      tick();
      if (done === 1'b1) begin
        done_count++;
        done_at = k;
      end
    end
    vectors++;
    if (done_count !== 1 || done_at !== 10) begin
      $display("FAIL ignored_done: got %0d pulses last at E+%0d, want 1 pulse at E+10", done_count, done_at);
      miscompares++;
    end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      #1;
      vectors++;
      if (rd_key !== a1_keys[i]) begin
        $display("FAIL ignored_rk[%0d]: got %h, want %h", i, rd_key, a1_keys[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(a1_keys[0]);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, keys_valid, done} !== 3'b000) begin
      $display("FAIL midreset_flags: got busy/valid/done=%b, want 000", {busy, keys_valid, done});
      miscompares++;
    end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      #1;
      vectors++;
      if (rd_key !== 128'h0) begin
        $display("FAIL midreset_rk[%0d]: got %h, want 0", i, rd_key);
        miscompares++;
      end
    end
    pulse_start(128'h0);
    repeat (9) tick();
    vectors++;
    if ({busy, keys_valid, done} !== 3'b100) begin
      $display("FAIL midreset_E+9: got busy/valid/done=%b, want 100", {busy, keys_valid, done});
      miscompares++;
    end
    tick();
    vectors++;
    if ({busy, keys_valid, done} !== 3'b011) begin
      $display("FAIL midreset_done: got busy/valid/done=%b, want 011", {busy, keys_valid, done});
      miscompares++;
    end
    rd_idx = 4'd10;
    #1;
    vectors++;
    if (rd_key !== ZERO_RK10) begin
      $display("FAIL midreset_rk10: got %h, want %h", rd_key, ZERO_RK10);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    start = 1'b1;
    key   = a1_keys[0];
    for (int k = 0; k <= 32; k++) begin
      tick();
      e = ((k % 11) == 10);
      vectors++;
      if ({busy, keys_valid, done} !== {~e, e, e}) begin
        $display("FAIL b2b_E+%0d: got busy/valid/done=%b, want %b", k, {busy, keys_valid, done}, {~e, e, e});
        miscompares++;
      end
    end
    start = 1'b0;
    key   = 128'h0;
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      #1;
      vectors++;
      if (rd_key !== a1_keys[i]) begin
        $display("FAIL b2b_rk[%0d]: got %h, want %h", i, rd_key, a1_keys[i]);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    key         = 128'h0;
    rd_idx      = 4'd0;
    a1_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips_a1();
    test_restart_from_done();
    test_zero_key();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Iterative AES-128 key-expansion unit, directly upstream of the combinational AES-128 decryption datapath.
- On a start pulse it captures a 128-bit cipher key and computes round keys 1..10, one per clock.
- It stores all 11 round keys (0..10) and exposes them through an indexed read port.
- The decryptor reads round key 10 first and round key 0 last.

Parameters:
None (AES-128 only; 10 rounds fixed; Rcon table fixed per FIPS-197).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request expansion of key; sampled each rising edge
key  input  128  cipher key, [0:127], bit 0 = MSB; w0 = key[0:31], w3 = key[96:127]
busy  output  1  high while expansion in progress
keys_valid  output  1  high when all 11 round keys are stored and stable
done  output  1  one-cycle pulse on the edge keys_valid rises
rd_idx  input  4  round-key index to read, 0..10
rd_key  output  128  round key rd_idx, [0:127] in the same word order as key; combinational from storage

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, busy=0, keys_valid=0, done=0, round counter=0.
  - All 11 key registers cleared to 0.
  - Reset overrides start and any in-flight expansion.
- States:
  - IDLE:
    - start=1 at edge E: key is written to rk[0], counter=1, state->EXPAND, busy=1, keys_valid=0.
  - EXPAND:
    - Each edge writes rk[cnt] = f(rk[cnt-1], Rcon[cnt]), then cnt++.
    - On the edge that writes rk[10]: state->DONE, busy=0, keys_valid=1, done=1.
    - rk[10] is written at edge E+10, so keys_valid is visible in the cycle after E+10.
  - DONE:
    - done returns to 0 after one cycle; keys_valid stays 1.
    - start=1 behaves exactly as in IDLE: keys_valid clears, a new key is captured, and expansion restarts.
- start while busy: ignored. The key is not recaptured, the counter is unaffected, and no error is raised.
- Key must be stable only in the cycle start is sampled; it is not re-read afterwards.
- Round function, with words w0..w3 of the previous key:
  - t = SubWord(RotWord(w3)) XOR (Rcon[r] || 0x000000)
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - RotWord is a left byte rotate: [a0 a1 a2 a3] -> [a1 a2 a3 a0].
  - SubWord applies the FIPS-197 forward S-box to each byte; 4 S-box lookups per cycle, implemented inside the block.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- rd_key:
  - Pure combinational mux of rk[rd_idx].
  - rd_idx 11..15 returns all-zero.
  - Reading during EXPAND returns whatever is currently stored: rk[0..cnt-1] are new, higher entries are stale from the previous key or zero after reset. Consumers use keys only while keys_valid=1.
- Throughput: one key per 11 cycles (capture + 10 rounds). No pipelining across keys.

Test Plan:
- FIPS-197 A.1 vector:
  - Stimulus: rst, then start with key=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: done at edge E+10, with busy high from E+0 through the cycle before E+10.
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 -> the input key.
- All-zero key:
  - rd_idx=1 -> 62636363626363636263636362636363.
  - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
  - rd_idx=12 -> 0.
- start asserted at E+3 with a different key during the A.1 expansion -> ignored; the final keys match A.1 exactly, and done fires once, at E+10.
- Reset mid-operation:
  - Stimulus: rst at E+5.
  - Required: next cycle busy=0, keys_valid=0, every rd_idx reads 0.
  - A subsequent start with the zero key completes normally in 10 cycles.
- Restart from DONE:
  - Stimulus: after A.1 completes, start with the zero key.
  - Required: keys_valid drops the next cycle, a new done fires 10 cycles later, and rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back:
  - Stimulus: start held high continuously.
  - Required: re-expansion begins on the edge after done with the same key. keys_valid pulses high for one cycle every 11 cycles and the keys match A.1.
